// File: rtl/rnn_sequence_loader.sv
// ---------------------------------------------------------------------------
// rnn_sequence_loader
//
// Upstream feeder for the recurrent network core. Scalar samples arrive on a
// valid/ready stream and are packed into sequences of SEQ_LEN samples. Only a
// complete sequence is presented to the core, one timestep per handshake,
// tagged with its step index and first/last markers. Two ping-pong banks let
// the next sequence fill while the current one drains.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   abort      drop the partially filled sequence in the write bank
//   in_valid   input sample valid
//   in_ready   loader can accept a sample (registered bank state only)
//   in_data    input sample
//   out_valid  a timestep of a complete sequence is available
//   out_ready  core accepts the current timestep
//   out_data   sample for the current timestep
//   out_step   timestep index 0..SEQ_LEN-1
//   out_first  high on step 0
//   out_last   high on step SEQ_LEN-1
//   seq_done   one-cycle pulse after the last timestep is accepted
//   seq_count  completed sequences, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module rnn_sequence_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_LEN    = 10,
    parameter int STEP_W     = $clog2(SEQ_LEN),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [STEP_W-1:0]     out_step,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  seq_done,
    output logic [CNT_W-1:0]      seq_count
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_state_t;

    localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(SEQ_LEN - 1);

    // Sample storage: two banks of SEQ_LEN samples.
    logic [DATA_WIDTH-1:0] r_mem [2][SEQ_LEN];

    bank_state_t           r_state [2];
    logic                  r_wr_bank;
    logic [STEP_W-1:0]     r_wr_idx;
    logic                  r_rd_bank;
    logic [STEP_W-1:0]     r_rd_idx;
    logic                  r_seq_done;
    logic [CNT_W-1:0]      r_seq_count;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_wr_last;
    logic                  w_rd_last;

    // Both handshake flags come from registered state only, so a drain that
    // empties the bank the writer is stalled on opens in_ready one cycle
    // later rather than combinationally.
    assign w_in_ready  = (r_state[r_wr_bank] != ST_FULL);
    assign w_out_valid = (r_state[r_rd_bank] == ST_FULL);

    // abort wins over a same-cycle sample; that sample is dropped.
    assign w_wr_fire   = in_valid && w_in_ready && !abort;
    assign w_rd_fire   = w_out_valid && out_ready;
    assign w_wr_last   = (r_wr_idx == LAST_IDX);
    assign w_rd_last   = (r_rd_idx == LAST_IDX);

    // Sample storage needs no reset: a bank is only read once it is FULL,
    // and every slot of a FULL bank was written during its fill.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_idx] <= in_data;
        end
    end

    // Bank state, pointers and completion bookkeeping.
    //
    // A write and a drain can never target the same bank in the same cycle:
    // writing needs the bank not FULL, draining needs it FULL. The two
    // r_state updates below therefore never collide, which lets a fill
    // completing on one bank and a drain completing on the other both land
    // in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0]  <= ST_EMPTY;
            r_state[1]  <= ST_EMPTY;
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_idx    <= '0;
            r_seq_done  <= 1'b0;
            r_seq_count <= '0;
        end else begin
            r_seq_done <= 1'b0;

            // Write side.
            if (abort) begin
                // Only a partially filled bank is discarded; a FULL bank the
                // writer is parked on still belongs to the read side.
                r_wr_idx <= '0;
                if (r_state[r_wr_bank] == ST_FILLING) begin
                    r_state[r_wr_bank] <= ST_EMPTY;
                end
            end else if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_state[r_wr_bank] <= ST_FULL;
                    r_wr_idx           <= '0;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_state[r_wr_bank] <= ST_FILLING;
                    r_wr_idx           <= r_wr_idx + 1'b1;
                end
            end

            // Read side.
            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_state[r_rd_bank] <= ST_EMPTY;
                    r_rd_idx           <= '0;
                    r_rd_bank          <= ~r_rd_bank;
                    r_seq_done         <= 1'b1;
                    r_seq_count        <= r_seq_count + 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

    // Outputs are functions of registered read pointers only, so they hold
    // steady for as long as the core withholds out_ready.
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_mem[r_rd_bank][r_rd_idx];
    assign out_step  = r_rd_idx;
    assign out_first = (r_rd_idx == '0);
    assign out_last  = w_rd_last;
    assign seq_done  = r_seq_done;
    assign seq_count = r_seq_count;

endmodule

// File: tb/tb_rnn_sequence_loader.sv
// ---------------------------------------------------------------------------
// tb_rnn_sequence_loader
//
// Directed bench for rnn_sequence_loader. Inputs are driven and outputs are
// sampled on the falling edge; a monitor records every accepted timestep at
// the rising edge so drained sequences can be compared against hand-computed
// expected contents.
// ---------------------------------------------------------------------------
module tb_rnn_sequence_loader;

    localparam int DW = 32;
    localparam int SL = 10;
    localparam int SW = $clog2(SL);
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_step;
    logic          out_first;
    logic          out_last;
    logic          seq_done;
    logic [CW-1:0] seq_count;

    int n_err  = 0;
    int n_chk  = 0;
    int n_done = 0;
    int stalls = 0;

    logic [DW-1:0] q_data [$];
    int            q_step [$];
    bit            q_first[$];
    bit            q_last [$];

    rnn_sequence_loader #(
        .DATA_WIDTH(DW),
        .SEQ_LEN   (SL),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_step (out_step),
        .out_first(out_first),
        .out_last (out_last),
        .seq_done (seq_done),
        .seq_count(seq_count)
    );

    always #5 clk = ~clk;

    // Accepted-timestep monitor.
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_step.push_back(int'(out_step));
                q_first.push_back(out_first);
                q_last.push_back(out_last);
            end
            if (seq_done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_step.delete();
        q_first.delete();
        q_last.delete();
        n_done = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        rst = 1'b0;
        clear_q();
    endtask

    // Present one sample and wait (bounded) until it is accepted. in_valid
    // is left high so consecutive pushes are back-to-back.
    task automatic push(input logic [DW-1:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        stalls += t;
        if (t >= 100) chk("push_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q_data.size() < n && t < 300) begin
            step();
            t++;
        end
        chk("drain_count", 64'(q_data.size()), 64'(n));
    endtask

    // Compare n recorded timesteps starting at entry off against samples
    // base, base+1, ... with steps restarting every SL entries.
    task automatic chk_seq(input string tag, input int off, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (off + i < q_data.size()) begin
                chk({tag, "_data"}, 64'(q_data[off+i]), 64'(base + i));
                chk({tag, "_step"}, 64'(q_step[off+i]), 64'((off + i) % SL));
            end else begin
                chk({tag, "_missing"}, 64'd0, 64'd1);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] snap_d;
        logic [SW-1:0] snap_s;
        bit            r;
        int            cyc;

        out_ready = 1'b0;
        do_reset();

        // Reset state.
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_seq_count", 64'(seq_count), 64'd0);
        chk("rst_seq_done",  64'(seq_done),  64'd0);

        // Basic: one sequence, step 0 visible right after the 10th accept.
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push(DW'(i));
        chk("basic_pre_valid", 64'(out_valid), 64'd0);
        push(DW'(10));
        in_valid = 1'b0;
        chk("basic_lat_valid", 64'(out_valid), 64'd1);
        chk("basic_lat_data",  64'(out_data),  64'd1);
        chk("basic_lat_first", 64'(out_first), 64'd1);
        wait_q(10);
        step();
        chk_seq("basic", 0, 1, 10);
        for (int i = 0; i < 10 && i < q_first.size(); i++) begin
            chk("basic_first", 64'(q_first[i]), 64'(i == 0));
            chk("basic_last",  64'(q_last[i]),  64'(i == 9));
        end
        chk("basic_done_pulses", 64'(n_done),    64'd1);
        chk("basic_seq_count",   64'(seq_count), 64'd1);
        chk("basic_idle_valid",  64'(out_valid), 64'd0);

        // Ping-pong: 20 back-to-back samples never stall the writer.
        do_reset();
        out_ready = 1'b1;
        stalls    = 0;
        for (int i = 1; i <= 20; i++) push(DW'(i));
        in_valid = 1'b0;
        chk("pp_stalls", 64'(stalls), 64'd0);
        wait_q(20);
        step();
        chk_seq("pp", 0, 1, 20);
        chk("pp_seq_count", 64'(seq_count), 64'd2);
        chk("pp_done",      64'(n_done),    64'd2);

        // Backpressure: both banks fill, writer is held off, output frozen.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) push(DW'(i));
        in_data = DW'(21);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_data",  64'(out_data), 64'd1);
            chk("bp_hold_step",  64'(out_step), 64'd0);
        end
        // Ten drain edges empty bank 0; in_ready is first seen after the
        // tenth, i.e. one cycle after the last-step handshake is presented.
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        chk("bp_bubble_cycles", 64'(cyc), 64'd10);
        for (int i = 21; i <= 30; i++) push(DW'(i));
        in_valid = 1'b0;
        wait_q(30);
        step();
        chk_seq("bp", 0, 1, 30);
        chk("bp_seq_count", 64'(seq_count), 64'd3);

        // Abort: the partial sequence and the colliding 5th sample vanish.
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        in_data = DW'(5);
        abort   = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 100; i <= 109; i++) push(DW'(i));
        in_valid = 1'b0;
        wait_q(10);
        step();
        chk_seq("abort", 0, 100, 10);
        chk("abort_extra", 64'(q_data.size()), 64'd10);

        // Stall stability under random out_ready.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) push(DW'(i));
        in_valid = 1'b0;
        for (int c = 0; c < 300 && q_data.size() < 10; c++) begin
            snap_d    = out_data;
            snap_s    = out_step;
            r         = 1'($urandom_range(0, 1));
            out_ready = r;
            step();
            if (!r) begin
                chk("stall_data", 64'(out_data), 64'(snap_d));
                chk("stall_step", 64'(out_step), 64'(snap_s));
            end
        end
        out_ready = 1'b0;
        step();
        chk("stall_count", 64'(q_data.size()), 64'd10);
        chk_seq("stall", 0, 1, 10);

        // Reset mid-drain with the other bank FULL.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) push(DW'(50 + i));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b0;
        chk("mid_step", 64'(out_step), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_q();
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_in_ready",  64'(in_ready),  64'd1);
        chk("mid_seq_count", 64'(seq_count), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) push(DW'(i));
        in_valid = 1'b0;
        wait_q(10);
        step();
        chk_seq("mid", 0, 1, 10);
        chk("mid_seq_count_after", 64'(seq_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rnn_sequence_loader.md
Name: rnn_sequence_loader

Overview:
Upstream feeder for the recurrent network core. It collects scalar input samples from a valid/ready stream into fixed-length sequences of SEQ_LEN samples. It then replays each complete sequence one timestep per handshake, tagged with step index and first/last markers, so the core sees whole sequences only. Two ping-pong banks let the next sequence fill while the current one drains.

Parameters:
DATA_WIDTH, 32, width of one input sample (matches core g_input).
SEQ_LEN, 10, samples per sequence; legal range is 2 or more.
STEP_W, $clog2(SEQ_LEN), derived; width of the step index.
CNT_W, 16, width of the completed-sequence counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
abort  in  1  discard the partially filled sequence in the write bank.
in_valid  in  1  input sample valid.
in_ready  out  1  loader can accept a sample.
in_data  in  DATA_WIDTH  input sample.
out_valid  out  1  timestep sample available to the core.
out_ready  in  1  core accepts the timestep.
out_data  out  DATA_WIDTH  sample for the current timestep.
out_step  out  STEP_W  timestep index t, from 0 to SEQ_LEN-1.
out_first  out  1  high when out_step==0.
out_last  out  1  high when out_step==SEQ_LEN-1.
seq_done  out  1  one-cycle pulse when the last timestep of a sequence is accepted.
seq_count  out  CNT_W  completed sequences; wraps modulo 2^CNT_W.

Behaviour:
- Storage: 2 banks × SEQ_LEN × DATA_WIDTH.
- Each bank has state EMPTY, FILLING or FULL.
- Write pointers: wr_bank and wr_idx. Read pointers: rd_bank and rd_idx.
- Reset (rst=1 at an edge):
  - wr_bank=rd_bank=0, wr_idx=rd_idx=0.
  - Both banks EMPTY, seq_count=0, seq_done=0.
  - Combinational outputs follow from these registers: in_ready=1, out_valid=0.
  - Reset mid-sequence discards all stored data.
- in_ready = (state[wr_bank] != FULL), using registered state only.
- Accept occurs when in_valid && in_ready && !abort:
  - mem[wr_bank][wr_idx] <= in_data.
  - The bank moves to FILLING.
  - If wr_idx==SEQ_LEN-1: the bank becomes FULL, wr_idx<=0 and wr_bank toggles. Otherwise wr_idx increments.
- abort (sync, one cycle):
  - wr_idx<=0; a FILLING bank returns to EMPTY.
  - FULL banks and the read side are unaffected.
  - abort overrides a same-cycle input accept; that sample is dropped.
- out_valid = (state[rd_bank]==FULL).
- out_data = mem[rd_bank][rd_idx]; out_step = rd_idx.
- out_data, out_step, out_first and out_last are held stable while out_valid && !out_ready.
- Drain handshake (out_valid && out_ready):
  - If rd_idx==SEQ_LEN-1: state[rd_bank]<=EMPTY, rd_idx<=0, rd_bank toggles, seq_done<=1 next cycle, seq_count increments.
  - Otherwise rd_idx increments.
- Latency:
  - The last sample is accepted at edge N; out_valid is high after edge N, so step 0 is visible one cycle after the sequence completes.
  - Steady state gives one timestep per cycle when out_ready=1.
- Same-cycle boundary events:
  - Bank fill-complete and other-bank drain-complete in the same cycle: both transitions take effect; the flags are independent.
  - Drain completes on the bank that wr_bank points at (writer stalled on FULL): the bank becomes EMPTY at that edge and in_ready rises the following cycle. This one-cycle bubble is required.
- Both banks FULL: in_ready=0 until the first drain completes. No sample may be lost or overwritten.
- Sequence order: strictly FIFO; bank 0 holds sequence 0, bank 1 holds sequence 1, and so on alternately.
- seq_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Basic: after reset, stream 1..10 with out_ready=1 → out_valid rises 1 cycle after sample 10. out_data=1..10 with out_step 0..9, out_first on step 0, out_last on step 9. seq_done pulses once; seq_count=1.
- Ping-pong: stream 20 samples back-to-back while out_ready=1 → in_ready stays 1 throughout. Two sequences emerge in order (1..10, then 11..20); seq_count=2.
- Backpressure: out_ready=0, push 25 samples → in_ready drops after sample 20. Samples 21–25 are held off and out_data stays 1 at step 0. Releasing out_ready drains 1..20 exactly; samples 21–25 are accepted only after the first drain completes, including the one-cycle bubble.
- Abort: push 4 samples, assert abort together with a 5th valid sample, then push 100..109 → the output sequence is 100..109. The 5th sample and the first 4 never appear.
- Stall stability: during drain, toggle out_ready randomly → every step 0..9 is delivered exactly once, and outputs are unchanged on cycles where out_ready=0.
- Reset mid-drain: assert rst at step 5 of a sequence with the other bank FULL → next cycle out_valid=0, in_ready=1 and seq_count=0. A fresh sequence 1..10 then drains from bank 0.
